// File: rtl/seq_decimal_palindrome.sv
// ---------------------------------------------------------------------------
// seq_decimal_palindrome
//
// Purpose:
//   Decides whether the decimal form of an unsigned binary operand reads the
//   same in both directions. The operand is first converted to BCD with a
//   sequential double-dabble (one bit per cycle). The number of significant
//   digits is then found, with leading zeros ignored. Digit pairs are then
//   compared from the outside in, one pair per cycle, and the walk stops at
//   the first mismatch.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request, sampled only while idle
//   n          in   [WIDTH-1:0] operand, captured on the accepted start
//   busy       out  high in every non-idle state, including DONE
//   done       out  one-cycle pulse, result valid
//   palindrome out  result, held until the next done or reset
//   ndigits    out  [$clog2(DIGITS+1)-1:0] significant digit count, updated
//                   with done (present only when DPAL_NDIGITS_EN is defined)
//
// Configuration macro: DPAL_NDIGITS_EN (enables the ndigits output).
// ---------------------------------------------------------------------------
module seq_decimal_palindrome #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             palindrome
`ifdef DPAL_NDIGITS_EN
    ,
    output logic [$clog2(DIGITS+1)-1:0] ndigits
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int LW = $clog2(DIGITS + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_LEN,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;        // operand, shifted out MSB first
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    k_q, k_d;
    logic             pal_q, pal_d;
    logic [LW-1:0]    ndig_q, ndig_d;

    // Selects digit idx of a packed BCD vector. A loop over the digit
    // positions keeps the index arithmetic in int and the select constant.
    function automatic logic [3:0] digit_at(input logic [BW-1:0] v, input int idx);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i == idx) r = v[4*i +: 4];
        end
        return r;
    endfunction

    // One double-dabble step: adjust each digit >= 5 by +3, then shift left
    // by one with the operand MSB entering digit 0.
    function automatic logic [BW-1:0] dabble(input logic [BW-1:0] v, input logic in_bit);
        logic [BW-1:0] adj;
        adj = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[BW-2:0], in_bit};
    endfunction

    logic [3:0] lo_digit, hi_digit;
    logic [LW-1:0] len_calc;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        n_d       = n_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        len_d     = len_q;
        k_d       = k_q;
        pal_d     = pal_q;
        ndig_d    = ndig_q;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);

        // Significant length: most significant nonzero digit + 1, minimum 1.
        len_calc = LW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) len_calc = LW'(i + 1);
        end

        lo_digit = digit_at(bcd_q, int'(k_q));
        hi_digit = digit_at(bcd_q, int'(len_q) - 1 - int'(k_q));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d       = n;
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_CONVERT;
                end
            end
            S_CONVERT: begin
                bcd_d     = dabble(bcd_q, n_q[WIDTH-1]);
                n_d       = n_q << 1;
                bit_cnt_d = bit_cnt_q + CW'(1);
                if (bit_cnt_q == CW'(WIDTH - 1)) state_d = S_LEN;
            end
            S_LEN: begin
                len_d = len_calc;
                k_d   = '0;
                if (len_calc <= LW'(1)) begin
                    pal_d   = 1'b1;
                    ndig_d  = len_calc;
                    state_d = S_DONE;
                end else begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (lo_digit != hi_digit) begin
                    pal_d   = 1'b0;
                    ndig_d  = len_q;
                    state_d = S_DONE;
                end else if (int'(k_q) == int'(len_q) / 2 - 1) begin
                    pal_d   = 1'b1;
                    ndig_d  = len_q;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + LW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            len_q     <= '0;
            k_q       <= '0;
            pal_q     <= 1'b0;
            ndig_q    <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
            len_q     <= len_d;
            k_q       <= k_d;
            pal_q     <= pal_d;
            ndig_q    <= ndig_d;
        end
    end

    assign palindrome = pal_q;
`ifdef DPAL_NDIGITS_EN
    assign ndigits = ndig_q;
`endif

endmodule
